// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 245 synchronous FIFO device-side responder.
package ft600_pkg;

    localparam int FT_DATA_WIDTH_DEF = 32;

    localparam int ERR_WR_OVERFLOW    = 0;
    localparam int ERR_RD_UNDERRUN    = 1;
    localparam int ERR_PROTO_CONFLICT = 2;
    localparam int ERR_W              = 3;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_RD_TA,
        BUS_RD,
        BUS_WR
    } bus_state_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ft600_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module ft600_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity, so a
    // reset flushes the FIFO without touching the array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ft600_dev_responder.sv
// Device-side FT600 245 sync FIFO responder: RX buffer toward the FPGA, TX buffer
// from it, flow-control flags, bus turnaround and sticky protocol error flags.
// Define FT600_LOOPBACK_EN to route the TX head straight into the RX buffer.
module ft600_dev_responder
    import ft600_pkg::*;
#(
    parameter int FT_DATA_WIDTH = FT_DATA_WIDTH_DEF,
    parameter int RX_DEPTH      = 64,
    parameter int TX_DEPTH      = 64,
    parameter int TXE_SLACK     = 3
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    output logic                                     ft_rxf_n,
    output logic                                     ft_txe_n,
    input  logic                                     ft_oe_n,
    input  logic                                     ft_rd_n,
    input  logic                                     ft_wr_n,
    input  logic [FT_DATA_WIDTH-1:0]                 ft_data_i,
    output logic [FT_DATA_WIDTH-1:0]                 ft_data_o,
    output logic                                     ft_data_oe,
    input  logic [FT_DATA_WIDTH/8-1:0]               ft_be_i,
    output logic [FT_DATA_WIDTH/8-1:0]               ft_be_o,
    input  logic [FT_DATA_WIDTH+FT_DATA_WIDTH/8-1:0] h2f_data,
    input  logic                                     h2f_valid,
    output logic                                     h2f_ready,
    output logic [FT_DATA_WIDTH+FT_DATA_WIDTH/8-1:0] f2h_data,
    output logic                                     f2h_valid,
    input  logic                                     f2h_ready,
    output logic [2:0]                               err_o
);

    localparam int BE_W   = be_width(FT_DATA_WIDTH);
    localparam int WORD_W = FT_DATA_WIDTH + BE_W;
    localparam int RX_AW  = $clog2(RX_DEPTH);
    localparam int TX_AW  = $clog2(TX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_COUNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [TX_AW:0] TX_SLACK_C    = (TX_AW+1)'(TXE_SLACK);

    bus_state_t state_q, state_d;

    logic [WORD_W-1:0] rx_head, tx_head, rx_push_data, hold_q;
    logic              rx_push, rx_pop, rx_empty, rx_full;
    logic              tx_push, tx_pop, tx_empty, tx_full;
    logic [RX_AW:0]    rx_count;
    logic [TX_AW:0]    tx_count, tx_free;
    logic              rd_strobe, wr_strobe, data_oe_d;
    logic [ERR_W-1:0]  err_q, err_set;

    ft600_sync_fifo #(.WIDTH(WORD_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count)
    );

    ft600_sync_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data ({ft_be_i, ft_data_i}),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUS_IDLE: begin
                if (!ft_oe_n) begin
                    state_d = BUS_RD_TA;
                end else if (!ft_wr_n) begin
                    state_d = BUS_WR;
                end
            end
            BUS_RD_TA: state_d = ft_oe_n ? BUS_IDLE : BUS_RD;
            BUS_RD: begin
                if (ft_oe_n) begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_WR: begin
                if (!ft_oe_n) begin
                    state_d = BUS_RD_TA;
                end else if (ft_wr_n) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    // A write strobe only counts while the FPGA is not also requesting the bus.
    always_comb begin
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
        data_oe_d = (state_d == BUS_RD_TA) || (state_d == BUS_RD);
        case (state_q)
            BUS_RD:           rd_strobe = !ft_rd_n;
            BUS_IDLE, BUS_WR: wr_strobe = !ft_wr_n && ft_oe_n;
            default:          ;
        endcase
    end

    assign rx_pop  = rd_strobe && !rx_empty;
    assign tx_push = wr_strobe;
    assign tx_free = TX_FULL_COUNT - tx_count;

    assign err_set[ERR_WR_OVERFLOW]    = wr_strobe && tx_full && !tx_pop;
    assign err_set[ERR_RD_UNDERRUN]    = rd_strobe && rx_empty;
    assign err_set[ERR_PROTO_CONFLICT] = !ft_oe_n && !ft_wr_n;

    // Once RX runs dry the bus keeps showing the last word handed to the FPGA.
    assign {ft_be_o, ft_data_o} = rx_empty ? hold_q : rx_head;
    assign err_o = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ft_data_oe <= 1'b0;
            ft_rxf_n   <= 1'b1;
            ft_txe_n   <= 1'b1;
            hold_q     <= '0;
            err_q      <= '0;
        end else begin
            ft_data_oe <= data_oe_d;
            ft_rxf_n   <= (rx_count == '0);
            ft_txe_n   <= !(tx_free > TX_SLACK_C);
            err_q      <= err_q | err_set;
            if (rx_pop) begin
                hold_q <= rx_head;
            end
        end
    end

`ifdef FT600_LOOPBACK_EN
    logic lb_move;
    logic unused_host;

    assign lb_move      = !tx_empty && !rx_full;
    assign rx_push      = lb_move;
    assign rx_push_data = tx_head;
    assign tx_pop       = lb_move;
    assign h2f_ready    = 1'b0;
    assign f2h_valid    = 1'b0;
    assign f2h_data     = '0;
    assign unused_host  = ^{h2f_data, h2f_valid, f2h_ready};
`else
    logic host_en_q;

    // Holds h2f_ready low through reset even though the empty RX is not full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_en_q <= 1'b0;
        end else begin
            host_en_q <= 1'b1;
        end
    end

    assign h2f_ready    = host_en_q && !rx_full;
    assign rx_push      = h2f_valid && h2f_ready;
    assign rx_push_data = h2f_data;
    assign f2h_valid    = !tx_empty;
    assign f2h_data     = tx_head;
    assign tx_pop       = f2h_valid && f2h_ready;
`endif

endmodule

// File: tb/tb_ft600_dev_responder.sv
// Scoreboard bench for ft600_dev_responder: stimulus queues expected words, monitors
// compare bus reads and host-side drains; flags and errors are checked directly.
module tb_ft600_dev_responder;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int WW = DW + BW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          ft_rxf_n, ft_txe_n, ft_data_oe;
    logic          ft_oe_n = 1'b1, ft_rd_n = 1'b1, ft_wr_n = 1'b1;
    logic [DW-1:0] ft_data_i = '0, ft_data_o;
    logic [BW-1:0] ft_be_i = '0, ft_be_o;
    logic [WW-1:0] h2f_data = '0, f2h_data;
    logic          h2f_valid = 1'b0, h2f_ready;
    logic          f2h_valid, f2h_ready = 1'b0;
    logic [2:0]    err_o;

    int            n_checks = 0;
    int            n_pass = 0;
    int            f2h_pops = 0;
    logic [WW-1:0] rd_exp_q[$];
    logic [WW-1:0] tx_exp_q[$];

    ft600_dev_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ft_rxf_n   (ft_rxf_n),
        .ft_txe_n   (ft_txe_n),
        .ft_oe_n    (ft_oe_n),
        .ft_rd_n    (ft_rd_n),
        .ft_wr_n    (ft_wr_n),
        .ft_data_i  (ft_data_i),
        .ft_data_o  (ft_data_o),
        .ft_data_oe (ft_data_oe),
        .ft_be_i    (ft_be_i),
        .ft_be_o    (ft_be_o),
        .h2f_data   (h2f_data),
        .h2f_valid  (h2f_valid),
        .h2f_ready  (h2f_ready),
        .f2h_data   (f2h_data),
        .f2h_valid  (f2h_valid),
        .f2h_ready  (f2h_ready),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus read monitor: every strobe cycle while the responder drives the bus.
    always @(negedge clk) begin
        if (reset_n && !ft_rd_n && ft_data_oe) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %0h with no word expected", {ft_be_o, ft_data_o});
            end else begin
                check("rd_word", {ft_be_o, ft_data_o}, rd_exp_q.pop_front());
            end
        end
    end

    // Host drain monitor.
    always @(negedge clk) begin
        if (reset_n && f2h_valid && f2h_ready) begin
            f2h_pops++;
            if (tx_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL f2h_unexpected: got %0h with no word expected", f2h_data);
            end else begin
                check("f2h_word", f2h_data, tx_exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic oe_n, input logic rd_n, input logic wr_n, input logic [WW-1:0] w);
        ft_oe_n = oe_n;
        ft_rd_n = rd_n;
        ft_wr_n = wr_n;
        {ft_be_i, ft_data_i} = w;
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [WW-1:0] w);
        int t = 0;
        h2f_data  = w;
        h2f_valid = 1'b1;
        while (!h2f_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("h2f_ready", h2f_ready, 1);
        @(posedge clk);
        #1;
        h2f_valid = 1'b0;
    endtask

    task automatic enter_read();
        drive(1'b0, 1'b1, 1'b1, '0);
        drive(1'b0, 1'b1, 1'b1, '0);
    endtask

    initial begin
        logic [WW-1:0] w;
        int            n;

        #1 reset_n = 1'b0;
        #2;
        check("rst_rxf_n", ft_rxf_n, 1);
        check("rst_txe_n", ft_txe_n, 1);
        check("rst_data_oe", ft_data_oe, 0);
        check("rst_data_o", ft_data_o, 0);
        check("rst_be_o", ft_be_o, 0);
        check("rst_h2f_ready", h2f_ready, 0);
        check("rst_f2h_valid", f2h_valid, 0);
        check("rst_err", err_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("txe_after_reset", ft_txe_n, 0);

`ifdef FT600_LOOPBACK_EN
        check("lb_h2f_ready", h2f_ready, 0);
        drive(1'b1, 1'b1, 1'b0, {4'hF, 32'hA5A5_A5A5});
        drive(1'b1, 1'b1, 1'b0, {4'h3, 32'h5A5A_5A5A});
        drive(1'b1, 1'b1, 1'b1, '0);
        n = 0;
        while (ft_rxf_n && n < 3) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("lb_rxf_fall", ft_rxf_n, 0);
        check("lb_f2h_valid", f2h_valid, 0);
        rd_exp_q.push_back({4'hF, 32'hA5A5_A5A5});
        rd_exp_q.push_back({4'h3, 32'h5A5A_5A5A});
        enter_read();
        drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b1, '0);
        check("lb_err", err_o, 0);
`else
        check("h2f_ready_after_reset", h2f_ready, 1);

        // Streaming read of four host words.
        for (int i = 1; i <= 4; i++) begin
            w = {4'hF, 32'h1111_1100 + 32'(i)};
            rd_exp_q.push_back(w);
            host_push(w);
        end
        check("rxf_low_with_data", ft_rxf_n, 0);
        check("oe_before_request", ft_data_oe, 0);
        drive(1'b0, 1'b1, 1'b1, '0);
        check("oe_rises", ft_data_oe, 1);
        drive(1'b0, 1'b1, 1'b1, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, '0);
        check("rxf_lags_last_pop", ft_rxf_n, 0);
        drive(1'b1, 1'b1, 1'b1, '0);
        check("rxf_high_after_drain", ft_rxf_n, 1);
        check("oe_falls", ft_data_oe, 0);
        check("err_clean_read", err_o, 0);

        // Fill TX while txe_n is low; the flag lags one cycle, so 62 writes land first.
        n = 0;
        while (!ft_txe_n && n < 70) begin
            w = {4'(n), 32'hC0DE_0000 + 32'(n)};
            tx_exp_q.push_back(w);
            drive(1'b1, 1'b1, 1'b0, w);
            n++;
        end
        check("txe_honored_writes", n, 62);
        for (int i = 62; i < 64; i++) begin
            w = {4'(i), 32'hC0DE_0000 + 32'(i)};
            tx_exp_q.push_back(w);
            drive(1'b1, 1'b1, 1'b0, w);
        end
        check("slack_writes_no_err", err_o[0], 0);
        drive(1'b1, 1'b1, 1'b0, {4'hE, 32'hDEAD_0040});
        check("overflow_err", err_o[0], 1);
        drive(1'b1, 1'b1, 1'b1, '0);
        check("txe_high_when_full", ft_txe_n, 1);
        f2h_ready = 1'b1;
        n = 0;
        while (f2h_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        f2h_ready = 1'b0;
        check("f2h_drain_count", f2h_pops, 64);
        check("f2h_valid_empty", f2h_valid, 0);
        @(posedge clk);
        #1;
        check("txe_low_after_drain", ft_txe_n, 0);

        // Read underrun: one word, three strobes.
        w = {4'h3, 32'hDEAD_BEEF};
        repeat (3) rd_exp_q.push_back(w);
        host_push(w);
        enter_read();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b1, '0);
        check("underrun_err", err_o[1], 1);
        check("underrun_hold", {ft_be_o, ft_data_o}, w);
        check("underrun_rxf", ft_rxf_n, 1);

        // oe_n and wr_n together: read wins, write dropped.
        w = {4'hA, 32'h0BAD_F00D};
        rd_exp_q.push_back(w);
        host_push(w);
        drive(1'b0, 1'b1, 1'b0, {4'hF, 32'h7777_7777});
        drive(1'b0, 1'b1, 1'b1, '0);
        drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b1, '0);
        check("conflict_err", err_o[2], 1);
        check("conflict_no_tx_push", f2h_valid, 0);

        // Reset while in BUS_RD with data pending.
        host_push({4'hF, 32'h2222_0001});
        host_push({4'hF, 32'h2222_0002});
        enter_read();
        check("rd_oe_before_reset", ft_data_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_oe_async", ft_data_oe, 0);
        check("reset_rxf", ft_rxf_n, 1);
        check("reset_err", err_o, 0);
        @(posedge clk);
        #1;
        ft_oe_n = 1'b1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("flushed_rxf", ft_rxf_n, 1);
        check("flushed_data_o", ft_data_o, 0);
        check("flushed_oe", ft_data_oe, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rd_queue_empty", rd_exp_q.size(), 0);
        check("tx_queue_empty", tx_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
